// File: rtl/fleet_pkg.sv
// Shared types, default constants and saturating helpers for the alien fleet controller.
// Pure declarations: no latency, no backpressure.
package fleet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARCH,
        ST_TURN,
        ST_LOCKOUT,
        ST_CLEARED,
        ST_LANDED
    } fleet_state_t;

    localparam int          DEF_NUM_ALIENS   = 16;
    localparam int          FLEET_IDX_W      = $clog2(DEF_NUM_ALIENS);
    localparam logic [15:0] DEF_BASE_PERIOD  = 16'd50000;
    localparam logic [15:0] DEF_MIN_PERIOD   = 16'd2000;
    localparam logic [15:0] DEF_PERIOD_STEP  = 16'd3000;
    localparam logic [15:0] DEF_STEP_WIDTH   = 16'd2;
    localparam logic [15:0] DEF_DESCEND_STEP = 16'd8;
    localparam logic [15:0] DEF_LAND_Y       = 16'd400;
    localparam logic [15:0] DEF_FIRE_PERIOD  = 16'd30000;

    // Subtract step but never go below floor_val (and never wrap).
    function automatic logic [15:0] floor_sub(input logic [15:0] val,
                                              input logic [15:0] step,
                                              input logic [15:0] floor_val);
        logic [16:0] limit;
        limit = {1'b0, floor_val} + {1'b0, step};
        if ({1'b0, val} < limit) begin
            return floor_val;
        end
        return val - step;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fleet_shooter_select.sv
// Round-robin shooter picker: fire timer expiry or shooter death starts a scan for the next alive alien.
// Scan advances one index per cycle; armed_vec is masked by alive_vec so a dead shooter drops at once.
module fleet_shooter_select
    import fleet_pkg::*;
#(
    parameter int          NUM_ALIENS  = DEF_NUM_ALIENS,
    parameter logic [15:0] FIRE_PERIOD = DEF_FIRE_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_ALIENS-1:0] alive_vec,
    input  logic                  enable,
    input  logic                  clear,
    output logic [NUM_ALIENS-1:0] armed_vec,
    output logic                  busy
);

    localparam int                    IDX_W    = $clog2(NUM_ALIENS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ALIENS - 1);
    localparam logic [NUM_ALIENS-1:0] ONE      = NUM_ALIENS'(1);

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      ptr_inc;
    logic [15:0]           timer;
    logic [NUM_ALIENS-1:0] armed_q;
    logic                  expire;
    logic                  shooter_died;

    assign ptr_inc      = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    assign expire       = enable && !busy && (({1'b0, timer} + 17'd1) >= {1'b0, FIRE_PERIOD});
    assign shooter_died = |(armed_q & ~alive_vec);
    assign armed_vec    = armed_q & alive_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            timer   <= '0;
            armed_q <= '0;
            busy    <= 1'b0;
        end else if (clear) begin
            ptr     <= '0;
            timer   <= '0;
            armed_q <= '0;
            busy    <= 1'b0;
        end else if (shooter_died) begin
            armed_q <= '0;
            busy    <= 1'b1;
            ptr     <= ptr_inc;
        end else if (busy) begin
            if (alive_vec[ptr]) begin
                armed_q <= ONE << ptr;
                busy    <= 1'b0;
            end else begin
                ptr <= ptr_inc;
            end
        end else if (expire) begin
            // Reselection starts past the current shooter so firing rotates round the fleet.
            timer   <= '0;
            armed_q <= '0;
            busy    <= 1'b1;
            ptr     <= ptr_inc;
        end else if (enable) begin
            timer <= timer + 16'd1;
        end
    end

endmodule

// File: rtl/alien_fleet_controller.sv
// Fleet controller: alive/armed vectors, march direction/speed/descent, wave-cleared and invaded status.
// All outputs registered (armed_vec gated by state); kills and reversals take effect at the next edge, no backpressure.
module alien_fleet_controller
    import fleet_pkg::*;
#(
    parameter int          NUM_ALIENS   = DEF_NUM_ALIENS,
    parameter logic [15:0] BASE_PERIOD  = DEF_BASE_PERIOD,
    parameter logic [15:0] MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter logic [15:0] PERIOD_STEP  = DEF_PERIOD_STEP,
    parameter logic [15:0] STEP_WIDTH   = DEF_STEP_WIDTH,
    parameter logic [15:0] DESCEND_STEP = DEF_DESCEND_STEP,
    parameter logic [15:0] LAND_Y       = DEF_LAND_Y,
    parameter logic [15:0] FIRE_PERIOD  = DEF_FIRE_PERIOD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_ALIENS-1:0]         edge_hit_vec,
    input  logic                          hit_valid,
    input  logic [$clog2(NUM_ALIENS)-1:0] hit_index,
    output logic [NUM_ALIENS-1:0]         alive_vec,
    output logic [NUM_ALIENS-1:0]         armed_vec,
    output logic                          movement_direction,
    output logic [15:0]                   movement_frequency,
    output logic [15:0]                   movement_width,
    output logic [15:0]                   fleet_y_offset,
    output logic                          descend_pulse,
    output logic                          kill_ack,
    output logic                          wave_cleared,
    output logic                          invaded
);

    localparam int                    IDX_W = $clog2(NUM_ALIENS);
    localparam int                    CNT_W = IDX_W + 1;
    localparam int                    EXT_W = 1 << IDX_W;
    localparam logic [NUM_ALIENS-1:0] ONE   = NUM_ALIENS'(1);

    fleet_state_t          state;
    fleet_state_t          state_next;
    logic [CNT_W-1:0]      alive_count;
    logic [16:0]           lock_cnt;
    logic [EXT_W-1:0]      alive_ext;
    logic [NUM_ALIENS-1:0] kill_mask;
    logic                  active;
    logic                  edge_seen;
    logic                  kill_ok;
    logic                  last_kill;
    logic                  do_turn;
    logic                  load_lock;
    logic [NUM_ALIENS-1:0] sel_armed;
    logic                  sel_busy;

    // Pad to a power of two so an out-of-range index reads a dead slot.
    always_comb begin
        alive_ext                   = '0;
        alive_ext[NUM_ALIENS-1:0]   = alive_vec;
    end

    assign active    = (state == ST_MARCH) || (state == ST_TURN) || (state == ST_LOCKOUT);
    assign edge_seen = (state == ST_MARCH) && |(edge_hit_vec & alive_vec);
    assign kill_ok   = active && hit_valid && alive_ext[hit_index];
    assign last_kill = kill_ok && (alive_count == CNT_W'(1));
    assign kill_mask = ONE << hit_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_turn    = 1'b0;
        load_lock  = 1'b0;
        if (start) begin
            state_next = ST_MARCH;
        end else begin
            case (state)
                ST_MARCH: begin
                    if (last_kill) begin
                        state_next = ST_CLEARED;
                    end else if (edge_seen) begin
                        state_next = ST_TURN;
                        do_turn    = 1'b1;
                    end
                end
                ST_TURN: begin
                    if (last_kill) begin
                        state_next = ST_CLEARED;
                    end else if (fleet_y_offset >= LAND_Y) begin
                        state_next = ST_LANDED;
                    end else begin
                        state_next = ST_LOCKOUT;
                        load_lock  = 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (last_kill) begin
                        state_next = ST_CLEARED;
                    end else if (lock_cnt == '0) begin
                        state_next = ST_MARCH;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_vec          <= '0;
            alive_count        <= '0;
            movement_direction <= 1'b1;
            movement_frequency <= BASE_PERIOD;
            fleet_y_offset     <= '0;
            lock_cnt           <= '0;
            descend_pulse      <= 1'b0;
            kill_ack           <= 1'b0;
            wave_cleared       <= 1'b0;
            invaded            <= 1'b0;
        end else begin
            descend_pulse <= 1'b0;
            kill_ack      <= 1'b0;
            wave_cleared  <= 1'b0;
            if (start) begin
                alive_vec          <= '1;
                alive_count        <= CNT_W'(NUM_ALIENS);
                movement_direction <= 1'b1;
                movement_frequency <= BASE_PERIOD;
                fleet_y_offset     <= '0;
                lock_cnt           <= '0;
                invaded            <= 1'b0;
            end else begin
                if (kill_ok) begin
                    alive_vec          <= alive_vec & ~kill_mask;
                    alive_count        <= alive_count - 1'b1;
                    movement_frequency <= floor_sub(movement_frequency, PERIOD_STEP, MIN_PERIOD);
                    kill_ack           <= 1'b1;
                    wave_cleared       <= last_kill;
                end
                // The reversal is committed on entry to TURN so descend_pulse lines up with the new offset.
                if (do_turn) begin
                    movement_direction <= ~movement_direction;
                    fleet_y_offset     <= sat_add(fleet_y_offset, DESCEND_STEP);
                    descend_pulse      <= 1'b1;
                end
                if (load_lock) begin
                    lock_cnt <= {1'b0, movement_frequency} + 17'd1;
                end else if ((state == ST_LOCKOUT) && (lock_cnt != '0)) begin
                    lock_cnt <= lock_cnt - 17'd1;
                end
                if (state_next == ST_LANDED) begin
                    invaded <= 1'b1;
                end
            end
        end
    end

    fleet_shooter_select #(
        .NUM_ALIENS  (NUM_ALIENS),
        .FIRE_PERIOD (FIRE_PERIOD)
    ) u_shooter (
        .clk       (clk),
        .rst_n     (rst_n),
        .alive_vec (alive_vec),
        .enable    ((state == ST_MARCH) || (state == ST_LOCKOUT)),
        .clear     (start || !active),
        .armed_vec (sel_armed),
        .busy      (sel_busy)
    );

    // No shooter is shown while a reselection scan is in flight or outside active play.
    assign armed_vec      = (active && !sel_busy) ? sel_armed : '0;
    assign movement_width = STEP_WIDTH;

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Directed bench: default-period instance for march/kill/shooter behaviour, short-period instance for landing and floor saturation.
module tb_alien_fleet_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] edge_hit_vec;
    logic        hit_valid;
    logic [3:0]  hit_index;

    logic [15:0] m_alive, m_armed, m_freq, m_width, m_y;
    logic        m_dir, m_descend, m_ack, m_clr, m_inv;
    logic [15:0] f_alive, f_armed, f_freq, f_width, f_y;
    logic        f_dir, f_descend, f_ack, f_clr, f_inv;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hv;
        logic [3:0]  idx;
        logic        ack;
        logic [15:0] alive;
        logic [15:0] freq;
        logic [15:0] ffreq;
        logic        clr;
    } vec_t;

    vec_t tbl [20];

    alien_fleet_controller #(
        .FIRE_PERIOD (16'd20)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .edge_hit_vec       (edge_hit_vec),
        .hit_valid          (hit_valid),
        .hit_index          (hit_index),
        .alive_vec          (m_alive),
        .armed_vec          (m_armed),
        .movement_direction (m_dir),
        .movement_frequency (m_freq),
        .movement_width     (m_width),
        .fleet_y_offset     (m_y),
        .descend_pulse      (m_descend),
        .kill_ack           (m_ack),
        .wave_cleared       (m_clr),
        .invaded            (m_inv)
    );

    alien_fleet_controller #(
        .BASE_PERIOD (16'd10),
        .MIN_PERIOD  (16'd2),
        .PERIOD_STEP (16'd3),
        .FIRE_PERIOD (16'd20)
    ) u_fast (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .edge_hit_vec       (edge_hit_vec),
        .hit_valid          (hit_valid),
        .hit_index          (hit_index),
        .alive_vec          (f_alive),
        .armed_vec          (f_armed),
        .movement_direction (f_dir),
        .movement_frequency (f_freq),
        .movement_width     (f_width),
        .fleet_y_offset     (f_y),
        .descend_pulse      (f_descend),
        .kill_ack           (f_ack),
        .wave_cleared       (f_clr),
        .invaded            (f_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int    cnt;
        logic  found;

        tbl[0]  = '{1'b1, 4'd5,  1'b1, 16'hFFDF, 16'd47000, 16'd7, 1'b0};
        tbl[1]  = '{1'b1, 4'd5,  1'b0, 16'hFFDF, 16'd47000, 16'd7, 1'b0};
        tbl[2]  = '{1'b0, 4'd6,  1'b0, 16'hFFDF, 16'd47000, 16'd7, 1'b0};
        tbl[3]  = '{1'b1, 4'd0,  1'b1, 16'hFFDE, 16'd44000, 16'd4, 1'b0};
        tbl[4]  = '{1'b1, 4'd1,  1'b1, 16'hFFDC, 16'd41000, 16'd2, 1'b0};
        tbl[5]  = '{1'b1, 4'd2,  1'b1, 16'hFFD8, 16'd38000, 16'd2, 1'b0};
        tbl[6]  = '{1'b1, 4'd3,  1'b1, 16'hFFD0, 16'd35000, 16'd2, 1'b0};
        tbl[7]  = '{1'b1, 4'd4,  1'b1, 16'hFFC0, 16'd32000, 16'd2, 1'b0};
        tbl[8]  = '{1'b1, 4'd6,  1'b1, 16'hFF80, 16'd29000, 16'd2, 1'b0};
        tbl[9]  = '{1'b1, 4'd7,  1'b1, 16'hFF00, 16'd26000, 16'd2, 1'b0};
        tbl[10] = '{1'b1, 4'd8,  1'b1, 16'hFE00, 16'd23000, 16'd2, 1'b0};
        tbl[11] = '{1'b1, 4'd9,  1'b1, 16'hFC00, 16'd20000, 16'd2, 1'b0};
        tbl[12] = '{1'b1, 4'd10, 1'b1, 16'hF800, 16'd17000, 16'd2, 1'b0};
        tbl[13] = '{1'b1, 4'd11, 1'b1, 16'hF000, 16'd14000, 16'd2, 1'b0};
        tbl[14] = '{1'b1, 4'd12, 1'b1, 16'hE000, 16'd11000, 16'd2, 1'b0};
        tbl[15] = '{1'b1, 4'd13, 1'b1, 16'hC000, 16'd8000,  16'd2, 1'b0};
        tbl[16] = '{1'b1, 4'd14, 1'b1, 16'h8000, 16'd5000,  16'd2, 1'b0};
        tbl[17] = '{1'b1, 4'd14, 1'b0, 16'h8000, 16'd5000,  16'd2, 1'b0};
        tbl[18] = '{1'b1, 4'd15, 1'b1, 16'h0000, 16'd2000,  16'd2, 1'b1};
        tbl[19] = '{1'b1, 4'd15, 1'b0, 16'h0000, 16'd2000,  16'd2, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        edge_hit_vec = '0;
        hit_valid = 1'b0;
        hit_index = '0;
        repeat (3) tick();

        chk("rst_alive", m_alive, 16'h0000);
        chk("rst_armed", m_armed, 16'h0000);
        chk("rst_dir", m_dir, 1'b1);
        chk("rst_freq", m_freq, 16'd50000);
        chk("rst_width", m_width, 16'd2);
        chk("rst_y", m_y, 16'd0);
        chk("rst_pulses", {m_descend, m_ack, m_clr}, 3'b000);
        chk("rst_invaded", m_inv, 1'b0);
        chk("rst_fast_freq", f_freq, 16'd10);
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_alive", m_alive, 16'hFFFF);
        chk("start_dir", m_dir, 1'b1);
        chk("start_freq", m_freq, 16'd50000);
        chk("start_y", m_y, 16'd0);
        chk("start_invaded", m_inv, 1'b0);

        edge_hit_vec = 16'h0008;
        tick();
        edge_hit_vec = '0;
        chk("turn_descend", m_descend, 1'b1);
        chk("turn_dir", m_dir, 1'b0);
        chk("turn_y", m_y, 16'd8);
        tick();
        chk("turn_descend_end", m_descend, 1'b0);
        repeat (8) tick();
        edge_hit_vec = 16'h0008;
        tick();
        edge_hit_vec = '0;
        chk("lockout_dir", m_dir, 1'b0);
        chk("lockout_y", m_y, 16'd8);
        chk("lockout_descend", m_descend, 1'b0);

        // Asynchronous reset while the fleet is locked out.
        rst_n = 1'b0;
        #1;
        chk("midrst_alive", m_alive, 16'h0000);
        chk("midrst_dir", m_dir, 1'b1);
        chk("midrst_freq", m_freq, 16'd50000);
        chk("midrst_y", m_y, 16'd0);
        chk("midrst_armed", m_armed, 16'h0000);
        chk("midrst_inv", m_inv, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hit_valid = tbl[i].hv;
            hit_index = tbl[i].idx;
            tick();
            chk($sformatf("kill%0d_ack", i), m_ack, tbl[i].ack);
            chk($sformatf("kill%0d_alive", i), m_alive, tbl[i].alive);
            chk($sformatf("kill%0d_freq", i), m_freq, tbl[i].freq);
            chk($sformatf("kill%0d_fast_freq", i), f_freq, tbl[i].ffreq);
            chk($sformatf("kill%0d_cleared", i), m_clr, tbl[i].clr);
        end
        hit_valid = 1'b0;
        chk("cleared_armed", m_armed, 16'h0000);

        start = 1'b1;
        tick();
        start = 1'b0;
        edge_hit_vec = 16'h0001;
        hit_valid = 1'b1;
        hit_index = 4'd0;
        tick();
        edge_hit_vec = '0;
        hit_valid = 1'b0;
        chk("same_descend", m_descend, 1'b1);
        chk("same_dir", m_dir, 1'b0);
        chk("same_ack", m_ack, 1'b1);
        chk("same_alive", m_alive, 16'hFFFE);
        chk("same_freq", m_freq, 16'd47000);
        chk("same_y", m_y, 16'd8);

        for (int i = 1; i < 4; i++) begin
            hit_valid = 1'b1;
            hit_index = 4'(i);
            tick();
        end
        hit_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (m_armed != 16'h0000) found = 1'b1;
        end
        chk("shooter_found", found, 1'b1);
        chk("shooter_first", m_armed, 16'h0010);
        hit_valid = 1'b1;
        hit_index = 4'd4;
        tick();
        hit_valid = 1'b0;
        chk("shooter_dead_clear", m_armed, 16'h0000);
        chk("shooter_kill_ack", m_ack, 1'b1);
        repeat (2) tick();
        chk("shooter_next", m_armed, 16'h0020);

        start = 1'b1;
        tick();
        start = 1'b0;
        edge_hit_vec = 16'hFFFF;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (f_descend) cnt++;
            if (f_inv) found = 1'b1;
        end
        edge_hit_vec = '0;
        chk("land_invaded", found, 1'b1);
        chk("land_reversals", cnt, 50);
        chk("land_y", f_y, 16'd400);
        hit_valid = 1'b1;
        hit_index = 4'd3;
        tick();
        hit_valid = 1'b0;
        chk("land_no_ack", f_ack, 1'b0);
        chk("land_alive", f_alive, 16'hFFFF);
        chk("land_armed", f_armed, 16'h0000);
        chk("land_y_frozen", f_y, 16'd400);
        chk("land_inv_level", f_inv, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_inv", f_inv, 1'b0);
        chk("restart_y", f_y, 16'd0);
        chk("restart_alive", f_alive, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
